// File: rtl/aes_sbox_dom_ctrl.sv
// aes_sbox_dom_ctrl
//   Sequencer for a four-stage DOM-masked AES S-box. Accepts a three-share
//   input byte, requests fresh randomness, walks the S-box stage enables
//   one cycle each, captures the result shares and holds them until the
//   consumer takes them.
//
// Ports
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   in_valid_i / in_ready_o           masked-byte request handshake
//   in_data_i, in_mask0_i, in_mask1_i input shares (S-box input basis)
//   prd_req_o / prd_ack_i, prd_data_i randomness request, 102-bit payload
//   sbox_we_o                         one-hot stage write enables
//   sbox_data_o, sbox_mask0_o,
//   sbox_mask1_o, sbox_prd_o          registered operands toward the S-box
//   sbox_data_i, sbox_mask0_i,
//   sbox_mask1_i                      S-box result shares
//   out_valid_o / out_ready_i         result handshake
//   out_data_o, out_mask0_o,
//   out_mask1_o                       registered result shares
//   busy_o                            high outside IDLE
//   err_o                             one-cycle pulse on randomness timeout
//
// Configuration
//   AES_SBOX_DOM_CTRL_CLEAR_EN  when defined, operand registers are zeroed
//   once the result is captured (and the shares on timeout), and result
//   registers are zeroed on the output handshake.

module aes_sbox_dom_ctrl #(
  parameter int unsigned PrdTimeout = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [7:0]   in_data_i,
  input  logic [7:0]   in_mask0_i,
  input  logic [7:0]   in_mask1_i,
  output logic         prd_req_o,
  input  logic         prd_ack_i,
  input  logic [101:0] prd_data_i,
  output logic [3:0]   sbox_we_o,
  output logic [7:0]   sbox_data_o,
  output logic [7:0]   sbox_mask0_o,
  output logic [7:0]   sbox_mask1_o,
  output logic [101:0] sbox_prd_o,
  input  logic [7:0]   sbox_data_i,
  input  logic [7:0]   sbox_mask0_i,
  input  logic [7:0]   sbox_mask1_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [7:0]   out_data_o,
  output logic [7:0]   out_mask0_o,
  output logic [7:0]   out_mask1_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRD,
    S1,
    S2,
    S3,
    S4,
    CAPT,
    OUT
  } state_e;

  localparam logic [7:0] PrdCntLast = 8'(PrdTimeout - 1);

  state_e     state_q, state_d;
  logic [7:0] prd_cnt_q;
  logic       accept;
  logic       prd_take;
  logic       timeout;
  logic       out_take;

  assign accept   = (state_q == IDLE) && in_valid_i;
  assign prd_take = (state_q == WAIT_PRD) && prd_ack_i;
  // An ack arriving in the last allowed cycle wins over the abort.
  assign timeout  = (state_q == WAIT_PRD) && !prd_ack_i && (prd_cnt_q == PrdCntLast);
  assign out_take = (state_q == OUT) && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_valid_i) state_d = WAIT_PRD;
      WAIT_PRD: begin
        if (prd_ack_i) begin
          state_d = S1;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      S1:       state_d = S2;
      S2:       state_d = S3;
      S3:       state_d = S4;
      S4:       state_d = CAPT;
      CAPT:     state_d = OUT;
      OUT:      if (out_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    in_ready_o  = 1'b0;
    prd_req_o   = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    sbox_we_o   = 4'b0000;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      WAIT_PRD: prd_req_o   = 1'b1;
      S1:       sbox_we_o   = 4'b0001;
      S2:       sbox_we_o   = 4'b0010;
      S3:       sbox_we_o   = 4'b0100;
      S4:       sbox_we_o   = 4'b1000;
      OUT:      out_valid_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prd_cnt_q <= '0;
      err_o     <= 1'b0;
    end else begin
      err_o <= timeout;
      if (accept) begin
        prd_cnt_q <= '0;
      end else if ((state_q == WAIT_PRD) && !prd_ack_i) begin
        prd_cnt_q <= prd_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sbox_data_o  <= '0;
      sbox_mask0_o <= '0;
      sbox_mask1_o <= '0;
      sbox_prd_o   <= '0;
      out_data_o   <= '0;
      out_mask0_o  <= '0;
      out_mask1_o  <= '0;
    end else begin
      if (accept) begin
        sbox_data_o  <= in_data_i;
        sbox_mask0_o <= in_mask0_i;
        sbox_mask1_o <= in_mask1_i;
      end
`ifdef AES_SBOX_DOM_CTRL_CLEAR_EN
      else if ((state_q == CAPT) || timeout) begin
        sbox_data_o  <= '0;
        sbox_mask0_o <= '0;
        sbox_mask1_o <= '0;
      end
`endif

      if (prd_take) begin
        sbox_prd_o <= prd_data_i;
      end
`ifdef AES_SBOX_DOM_CTRL_CLEAR_EN
      else if (state_q == CAPT) begin
        sbox_prd_o <= '0;
      end
`endif

      if (state_q == CAPT) begin
        out_data_o  <= sbox_data_i;
        out_mask0_o <= sbox_mask0_i;
        out_mask1_o <= sbox_mask1_i;
      end
`ifdef AES_SBOX_DOM_CTRL_CLEAR_EN
      else if (out_take) begin
        out_data_o  <= '0;
        out_mask0_o <= '0;
        out_mask1_o <= '0;
      end
`endif
    end
  end

`ifndef AES_SBOX_DOM_CTRL_CLEAR_EN
  // Result registers simply hold after the handshake in this build.
  logic unused_out_take;
  assign unused_out_take = out_take;
`endif

endmodule

// File: tb/tb_aes_sbox_dom_ctrl.sv
// tb_aes_sbox_dom_ctrl
//   Directed bench for aes_sbox_dom_ctrl. A behavioural four-stage S-box
//   stands in for the masked datapath (algorithmic GF(2^8) inverse plus
//   affine map); expected results are hand-computed S-box constants pushed
//   to a scoreboard and popped by a monitor on each output handshake.

module tb_aes_sbox_dom_ctrl;

`ifdef AES_SBOX_DOM_CTRL_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0, in_mask0 = '0, in_mask1 = '0;
  logic         prd_req;
  logic         prd_ack = 1'b0;
  logic [101:0] prd_data = '0;
  logic [3:0]   sbox_we;
  logic [7:0]   sbox_data_o, sbox_mask0_o, sbox_mask1_o;
  logic [101:0] sbox_prd;
  logic [7:0]   sbox_data_i = '0, sbox_mask0_i = '0, sbox_mask1_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data, out_mask0, out_mask1;
  logic         busy, err;

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  int unsigned  n_err = 0;
  logic [7:0]   sb[$];

  // model state
  int unsigned  stg = 0;
  int unsigned  walk_n = 0;
  bit           walk_bad = 1'b0;
  logic [23:0]  hs;
  logic [15:0]  hr;

  aes_sbox_dom_ctrl #(.PrdTimeout(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_mask0_i(in_mask0), .in_mask1_i(in_mask1),
    .prd_req_o(prd_req), .prd_ack_i(prd_ack), .prd_data_i(prd_data),
    .sbox_we_o(sbox_we),
    .sbox_data_o(sbox_data_o), .sbox_mask0_o(sbox_mask0_o), .sbox_mask1_o(sbox_mask1_o),
    .sbox_prd_o(sbox_prd),
    .sbox_data_i(sbox_data_i), .sbox_mask0_i(sbox_mask0_i), .sbox_mask1_i(sbox_mask1_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_mask0_o(out_mask0), .out_mask1_o(out_mask1),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Behavioural DOM S-box: latches operands on stage 1, insists they stay
  // put and that stages arrive in order, produces re-masked result on stage 4.
  always @(posedge clk) begin
    if (!rst_n) begin
      stg = 0;
    end else if (sbox_we != 4'b0000) begin
      if (sbox_we != (4'b0001 << stg)) walk_bad = 1'b1;
      if (stg == 0) begin
        hs = {sbox_data_o, sbox_mask0_o, sbox_mask1_o};
        hr = sbox_prd[15:0];
      end else if (({sbox_data_o, sbox_mask0_o, sbox_mask1_o} != hs) || (sbox_prd[15:0] != hr)) begin
        walk_bad = 1'b1;
      end
      walk_n++;
      stg++;
      if (stg >= 4) begin
        sbox_data_i  <= sbox(hs[23:16] ^ hs[15:8] ^ hs[7:0]) ^ hr[7:0] ^ hr[15:8];
        sbox_mask0_i <= hr[7:0];
        sbox_mask1_i <= hr[15:8];
        stg = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: scoreboard pop on every result handshake
  always @(negedge clk) begin
    logic [7:0] e;
    if (err) n_err++;
    if (out_valid && out_ready) begin
      chk("sb_depth", 128'(sb.size()), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sbox_result", 128'(out_data ^ out_mask0 ^ out_mask1), 128'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] exp_y,
                        input logic [7:0] m0, input logic [7:0] m1,
                        input int unsigned ack_dly, input int unsigned rdy_dly,
                        input bit poke);
    logic [127:0] rnd;
    logic [101:0] prd;
    logic [7:0]   ed, e0, e1;
    int unsigned  lat;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    prd = rnd[101:0];
    ed  = exp_y ^ prd[7:0] ^ prd[15:8];
    e0  = prd[7:0];
    e1  = prd[15:8];
    walk_n = 0;
    walk_bad = 1'b0;
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = x ^ m0 ^ m1;
    in_mask0 = m0;
    in_mask1 = m1;
    sb.push_back(exp_y);
    tick();
    in_valid = 1'b0;
    lat = 0;
    repeat (ack_dly) begin tick(); lat++; end
    prd_ack  = 1'b1;
    prd_data = prd;
    tick(); lat++;
    prd_ack = 1'b0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk("latency", 128'(lat), 128'(6 + ack_dly));
    chk("sbox_prd_after_capt", 128'(sbox_prd), ClearEn ? 128'(0) : 128'(prd));
    chk("sbox_data_after_capt", 128'(sbox_data_o), ClearEn ? 128'(0) : 128'(x ^ m0 ^ m1));
    chk("out_shares", 128'({out_data, out_mask0, out_mask1}), 128'({ed, e0, e1}));
    if (poke) in_valid = 1'b1;
    for (int i = 0; i < int'(rdy_dly); i++) begin
      tick();
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_shares", 128'({out_data, out_mask0, out_mask1}), 128'({ed, e0, e1}));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_idle", 128'({in_ready, busy, out_valid}), 128'(3'b100));
    chk("out_after_take", 128'({out_data, out_mask0, out_mask1}),
        ClearEn ? 128'(0) : 128'({ed, e0, e1}));
    chk("we_walk", 128'({walk_bad, 4'(walk_n)}), 128'({1'b0, 4'd4}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached with %0d failures", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rnd;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_ctrl", 128'({in_ready, prd_req, out_valid, busy, err, sbox_we}), 128'(9'b1_0000_0000));
    chk("rst_regs", 128'({sbox_data_o, sbox_mask0_o, sbox_mask1_o, out_data, out_mask0, out_mask1}), 128'(0));
    chk("rst_prd", 128'(sbox_prd), 128'(0));

    run_op(8'h00, 8'h63, 8'h00, 8'h00, 0, 0, 1'b0);
    run_op(8'h01, 8'h7c, 8'ha5, 8'h3c, 2, 10, 1'b1);
    run_op(8'hff, 8'h16, 8'h0f, 8'hf0, 15, 1, 1'b0);
    run_op(8'h10, 8'hca, 8'h5e, 8'h81, 14, 0, 1'b0);

    // prd_ack outside WAIT_PRD has no effect
    prd_ack = 1'b1;
    tick();
    prd_ack = 1'b0;
    chk("ack_in_idle", 128'({in_ready, busy, prd_req}), 128'(3'b100));

    // randomness never arrives
    in_valid = 1'b1; in_data = 8'h5a; in_mask0 = 8'h11; in_mask1 = 8'h22;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    chk("to_still_waiting", 128'({prd_req, err}), 128'(2'b10));
    tick();
    chk("to_err_pulse", 128'({err, in_ready, busy}), 128'(3'b110));
    chk("to_shares", 128'(sbox_data_o), ClearEn ? 128'(0) : 128'(8'h5a));
    tick();
    chk("to_err_once", 128'(err), 128'(0));

    run_op(8'h53, 8'hed, 8'h77, 8'h99, 1, 0, 1'b0);

    // reset while in S2
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = 1'b1; in_data = 8'h3c; in_mask0 = 8'hc3; in_mask1 = 8'h0f;
    tick();
    in_valid = 1'b0;
    prd_ack = 1'b1; prd_data = rnd[101:0];
    tick();
    prd_ack = 1'b0;
    tick();
    chk("s2_we", 128'(sbox_we), 128'(4'b0010));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ctrl", 128'({in_ready, prd_req, out_valid, busy, err, sbox_we}), 128'(9'b1_0000_0000));
    chk("mid_rst_regs", 128'({sbox_data_o, sbox_mask0_o, sbox_mask1_o, out_data, out_mask0, out_mask1}), 128'(0));
    chk("mid_rst_prd", 128'(sbox_prd), 128'(0));

    for (int n = 0; n < 1000; n++) begin
      run_op(8'h53, 8'hed, 8'($urandom()), 8'($urandom()), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    tick(); tick();
    chk("err_pulses", 128'(n_err), 128'(1));
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_sbox_dom_ctrl.md
AES_SBOX_DOM_CTRL -- requirements
Module: aes_sbox_dom_ctrl

Interface
REQ-001 Parameter: PrdTimeout, default 16, max WAIT_PRD cycles before abort (range 2..255).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 in_valid_i / in_ready_o  in / out  1 / 1  masked-byte request handshake.
REQ-005 in_data_i, in_mask0_i, in_mask1_i  in  8 each  three shares of the input byte, in S-box input basis.
REQ-006 prd_req_o / prd_ack_i  out / in  1 / 1  fresh-randomness request handshake.
REQ-007 prd_data_i  in  102  randomness, sampled on prd_req_o & prd_ack_i.
REQ-008 sbox_we_o  out  4  one-hot DOM S-box stage write enables.
REQ-009 sbox_data_o, sbox_mask0_o, sbox_mask1_o  out  8 each  registered input shares held toward the S-box.
REQ-010 sbox_prd_o  out  102  registered randomness held toward the S-box.
REQ-011 sbox_data_i, sbox_mask0_i, sbox_mask1_i  in  8 each  S-box output shares.
REQ-012 out_valid_o / out_ready_i  out / in  1 / 1  result handshake.
REQ-013 out_data_o, out_mask0_o, out_mask1_o  out  8 each  registered result shares.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 err_o  out  1  one-cycle pulse on randomness timeout.

Function
REQ-016 FSM states: IDLE, WAIT_PRD, S1, S2, S3, S4, CAPT, OUT; exactly one state active at a time.
REQ-017 IDLE: in_ready_o=1; on in_valid_i, capture the three shares into sbox_*_o, go to WAIT_PRD.
REQ-018 WAIT_PRD: prd_req_o=1; on prd_ack_i, capture prd_data_i into sbox_prd_o, go to S1.
REQ-019 S1..S4: sbox_we_o = 0001, 0010, 0100, 1000 respectively, each for exactly one cycle; otherwise sbox_we_o=0000.
REQ-020 CAPT: register sbox_*_i into out_*_o, go to OUT.
REQ-021 OUT: out_valid_o=1, out_* stable; on out_ready_i, go to IDLE; a new request is accepted no earlier than the next cycle.
REQ-022 Latency: accept at cycle t with prd_ack_i at t+1 gives out_valid_o at t+7, the minimum.
REQ-023 in_ready_o, prd_req_o and out_valid_o are pure functions of the state; no combinational path from any input to them.
REQ-024 sbox_*_o and sbox_prd_o stay constant from capture until CAPT completes; each operation consumes fresh randomness, never reused.
REQ-025 Timeout: an 8-bit counter clears on entry to WAIT_PRD and increments each cycle without prd_ack_i; when it reaches PrdTimeout-1 without ack, pulse err_o and go to IDLE.
REQ-026 prd_ack_i in the timeout cycle takes priority: no err_o, proceed to S1.
REQ-027 prd_ack_i, out_ready_i and in_valid_i are ignored outside WAIT_PRD, OUT and IDLE respectively.

Reset
REQ-028 With rst_ni low at a clock edge: state=IDLE, counter=0, all share/prd/out registers=0.
REQ-029 Reset outputs: in_ready_o=1; prd_req_o, out_valid_o, busy_o, err_o=0; sbox_we_o=0000.
REQ-030 Reset mid-operation (any state) aborts it with no err_o and no out_valid_o.

Configuration
REQ-031 Macro AES_SBOX_DOM_CTRL_CLEAR_EN defined: zero sbox_*_o and sbox_prd_o on the CAPT edge, zero out_*_o on the OUT handshake edge, zero captured shares on timeout.
REQ-032 Macro not defined: these registers retain their last values; all other behaviour is identical.

Verification
REQ-033 Shares 0x00/0x00/0x00, prd_ack_i at t+1 -> out_valid_o at t+7; out_data_o^out_mask0_o^out_mask1_o = 0x63.
REQ-034 Random shares, fixed unmasked input x, 1000 runs -> XOR of output shares equals golden S-box model(x) every time; sbox_we_o walks 0001,0010,0100,1000 exactly once per run.
REQ-035 prd_ack_i held low, PrdTimeout=16 -> err_o pulses once 16 cycles after WAIT_PRD entry; FSM in IDLE; no out_valid_o.
REQ-036 out_ready_i held low 10 cycles in OUT -> out_valid_o and out_* stable; in_ready_o=0 throughout; handshake cycle returns to IDLE.
REQ-037 rst_ni low during S2 -> next cycle IDLE, sbox_we_o=0000, in_ready_o=1, all registers 0.
REQ-038 With AES_SBOX_DOM_CTRL_CLEAR_EN defined -> sbox_prd_o reads 0 the cycle after CAPT; without the macro it still holds the captured value.
